// File: rtl/dff_pipe_pkg.sv
// Shared definitions for the dff_pipe elastic register pipeline.
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 4;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int clog2_cnt(input int depth);
    int w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < depth + 1) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Handshake bundle for dff_pipe; par_err exists only when DFF_PIPE_PARITY_EN is defined.
interface dff_pipe_if
  import dff_pkg::*;
#(
  parameter int WIDTH = DFF_DEFAULT_WIDTH,
  parameter int DEPTH = 3
) ();

  localparam int CW = clog2_cnt(DEPTH);

  logic             sclr;
  logic             sset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
`ifdef DFF_PIPE_PARITY_EN
  logic             par_err;
`endif

  modport master (
`ifdef DFF_PIPE_PARITY_EN
    input  par_err,
`endif
    output sclr, sset, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
`ifdef DFF_PIPE_PARITY_EN
    output par_err,
`endif
    input  sclr, sset, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// One data/valid register of the pipeline; flush beats set beats normal advance.
module dff_pipe_stage #(
  parameter int            DW    = 4,
  parameter logic [DW-1:0] SET_D = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  input  logic          i_load,
  input  logic          i_sclr,
  input  logic          i_sset,
  input  logic [DW-1:0] i_d,
  output logic          o_v,
  output logic [DW-1:0] o_d
);

  logic          r_v;
  logic [DW-1:0] r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (i_sclr) begin
      r_v <= 1'b0;
    end else if (i_sset) begin
      r_d <= SET_D;
    end else if (i_adv) begin
      r_v <= i_load;
      // Data only moves with a valid token, so empty stages keep stale data.
      if (i_load) r_d <= i_d;
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH elastic register pipeline with flush, set and occupancy count.
// Optional stored parity and par_err output under DFF_PIPE_PARITY_EN.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input logic         clk,
  input logic         rst,
  dff_pipe_if.slave   bus
);

  localparam int CW = clog2_cnt(DEPTH);
`ifdef DFF_PIPE_PARITY_EN
  localparam int            DW    = WIDTH + 1;
  localparam logic [DW-1:0] SET_D = {^SET_VALUE, SET_VALUE};
`else
  localparam int            DW    = WIDTH;
  localparam logic [DW-1:0] SET_D = SET_VALUE;
`endif

  logic [DEPTH-1:0]         w_v;
  logic [DEPTH-1:0]         w_adv;
  logic [DEPTH-1:0]         w_ld;
  logic [DEPTH-1:0][DW-1:0] w_d;
  logic [DEPTH-1:0][DW-1:0] w_di;
  logic [DW-1:0]            w_in_d;
  logic                     w_in_hs;
  logic                     w_out_hs;
  logic [CW-1:0]            r_count;

`ifdef DFF_PIPE_PARITY_EN
  assign w_in_d = {^bus.in_data, bus.in_data};
`else
  assign w_in_d = bus.in_data;
`endif

  // A stage may advance if it is empty or everything downstream of it can move.
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = ~w_v[DEPTH-1] | bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_adv[i] = ~w_v[i] | w_adv[i+1];
    end
  end

  always_comb begin
    w_ld    = '0;
    w_di    = '0;
    w_ld[0] = bus.in_valid;
    w_di[0] = w_in_d;
    for (int i = 1; i < DEPTH; i++) begin
      w_ld[i] = w_v[i-1];
      w_di[i] = w_d[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dff_pipe_stage #(
      .DW    (DW),
      .SET_D (SET_D)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_adv  (w_adv[g]),
      .i_load (w_ld[g]),
      .i_sclr (bus.sclr),
      .i_sset (bus.sset),
      .i_d    (w_di[g]),
      .o_v    (w_v[g]),
      .o_d    (w_d[g])
    );
  end

  assign w_in_hs  = bus.in_valid & bus.in_ready;
  assign w_out_hs = bus.out_valid & bus.out_ready;

  // Tokens are only created at the input and destroyed at the output, so the
  // popcount of the valids can be tracked incrementally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (bus.sclr) begin
      r_count <= '0;
    end else if (!bus.sset) begin
      r_count <= r_count + CW'(w_in_hs) - CW'(w_out_hs);
    end
  end

  assign bus.in_ready  = w_adv[0] & ~bus.sset;
  assign bus.out_valid = w_v[DEPTH-1];
  assign bus.out_data  = w_d[DEPTH-1][WIDTH-1:0];
  assign bus.count     = r_count;

`ifdef DFF_PIPE_PARITY_EN
  assign bus.par_err = w_v[DEPTH-1] & ((^w_d[DEPTH-1][WIDTH-1:0]) != w_d[DEPTH-1][WIDTH]);
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=4, DEPTH=3) against a word-queue reference model.
module tb_dff_pipe;

  localparam int         DEPTH = 3;
  localparam logic [3:0] SETV  = 4'hF;

  typedef struct {
    logic [3:0] data;
    int         pos;
  } word_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_vec = 0;
  int    n_miss = 0;
  word_t q[$];

  dff_pipe_if #(.WIDTH(4), .DEPTH(DEPTH)) bus ();

  dff_pipe #(.WIDTH(4), .DEPTH(DEPTH), .SET_VALUE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: each word carries its stage index; the head leaves when it sits at
  // the last stage with out_ready, every other word steps forward unless the
  // word ahead of it ends up directly in front.
  task automatic model_edge(input logic iv, input logic [3:0] id, input logic ordy,
                            input logic sc, input logic ss);
    int prev;
    int np;
    bit rdy;
    if (sc) begin
      q.delete();
    end else if (ss) begin
      foreach (q[k]) q[k].data = SETV;
    end else begin
      rdy = (q.size() < DEPTH) || ordy;
      if (q.size() > 0 && q[0].pos == DEPTH - 1 && ordy) void'(q.pop_front());
      prev = DEPTH;
      foreach (q[k]) begin
        np = q[k].pos + 1;
        if (np > prev - 1) np = prev - 1;
        q[k].pos = np;
        prev = np;
      end
      if (iv && rdy) q.push_back('{data: id, pos: 0});
    end
  endtask

  function automatic logic m_out_valid();
    return (q.size() > 0) && (q[0].pos == DEPTH - 1);
  endfunction

  function automatic logic [3:0] m_out_data();
    return (q.size() > 0) ? q[0].data : 4'h0;
  endfunction

  function automatic logic m_in_ready();
    return !bus.sset && ((q.size() < DEPTH) || bus.out_ready);
  endfunction

  task automatic drive(input logic iv, input logic [3:0] id, input logic ordy,
                       input logic sc = 1'b0, input logic ss = 1'b0);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.sclr      = sc;
    bus.sset      = ss;
    #1;
  endtask

  task automatic tick();
    logic iv, ordy, sc, ss;
    logic [3:0] id;
    iv = bus.in_valid; id = bus.in_data; ordy = bus.out_ready;
    sc = bus.sclr; ss = bus.sset;
    @(posedge clk);
    if (!rst) model_edge(iv, id, ordy, sc, ss);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 4'h0, 0);
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.count !== 2'd0) begin n_miss++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    rst = 1'b0;
    q.delete();
    drive(1, 4'h5, 0); tick();
    drive(1, 4'h6, 0); tick();
    drive(1, 4'h7, 0); tick();
    drive(0, 4'h0, 0);
    n_vec++; if (bus.count !== 2'd3) begin n_miss++; $display("FAIL rst_prefill_count: got %0d want 3", bus.count); end
    #3;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_async_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.count !== 2'd0) begin n_miss++; $display("FAIL rst_async_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.out_data !== 4'h0) begin n_miss++; $display("FAIL rst_async_data: got %h want 0", bus.out_data); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_async_ready: got %b want 1", bus.in_ready); end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    for (int c = 0; c < 8; c++) begin
      drive(c < 4, 4'(c + 1), 1);
      n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL stream_ready c%0d: got %b want 1", c, bus.in_ready); end
      if (c >= 3 && c <= 6) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(c - 2)) begin
          n_miss++; $display("FAIL stream_out c%0d: got v=%b d=%h want v=1 d=%h", c, bus.out_valid, bus.out_data, 4'(c - 2));
        end
      end
      if (c == 3 || c == 4) begin
        n_vec++; if (bus.count !== 2'd3) begin n_miss++; $display("FAIL stream_count c%0d: got %0d want 3", c, bus.count); end
      end
      if (c == 7) begin
        n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL stream_empty: got %b want 0", bus.out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [3:0] got[$];
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'(8 + k), 0);
      n_vec++; if (bus.in_ready !== m_in_ready()) begin n_miss++; $display("FAIL bp_ready k%0d: got %b want %b", k, bus.in_ready, m_in_ready()); end
      if (bus.in_ready === 1'b1) acc++;
      tick();
    end
    drive(0, 4'h0, 0);
    n_vec++; if (acc != 3) begin n_miss++; $display("FAIL bp_accepted: got %0d want 3", acc); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_miss++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
    n_vec++; if (bus.count !== 2'd3) begin n_miss++; $display("FAIL bp_count: got %0d want 3", bus.count); end
    for (int c = 0; c < 10; c++) begin
      drive(0, 4'h0, 1);
      if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
      tick();
    end
    n_vec++; if (got.size() != 3) begin n_miss++; $display("FAIL bp_drain_len: got %0d want 3", got.size()); end
    for (int j = 0; j < got.size() && j < 3; j++) begin
      n_vec++; if (got[j] !== 4'(8 + j)) begin n_miss++; $display("FAIL bp_order w%0d: got %h want %h", j, got[j], 4'(8 + j)); end
    end
  endtask

  task automatic test_bubble();
    drive(1, 4'hA, 0); tick();
    for (int c = 1; c < 5; c++) begin
      drive(0, 4'h0, 0);
      n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL bubble_ready c%0d: got %b want 1", c, bus.in_ready); end
      if (c == 3) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA) begin
          n_miss++; $display("FAIL bubble_out: got v=%b d=%h want v=1 d=a", bus.out_valid, bus.out_data);
        end
        n_vec++; if (bus.count !== 2'd1) begin n_miss++; $display("FAIL bubble_count: got %0d want 1", bus.count); end
      end
      tick();
    end
    drive(0, 4'h0, 1); tick();
  endtask

  task automatic test_sset_sclr();
    for (int k = 0; k < 3; k++) begin drive(1, 4'(k + 1), 0); tick(); end
    drive(1, 4'h4, 0, 0, 1);
    n_vec++; if (bus.in_ready !== 1'b0) begin n_miss++; $display("FAIL sset_ready: got %b want 0", bus.in_ready); end
    tick();
    drive(0, 4'h0, 0);
    n_vec++; if (bus.count !== 2'd3) begin n_miss++; $display("FAIL sset_count: got %0d want 3", bus.count); end
    for (int j = 0; j < 3; j++) begin
      drive(0, 4'h0, 1);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== SETV) begin
        n_miss++; $display("FAIL sset_out w%0d: got v=%b d=%h want v=1 d=f", j, bus.out_valid, bus.out_data);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin drive(1, 4'(k + 4), 0); tick(); end
    drive(1, 4'h7, 0, 1, 0); tick();
    drive(0, 4'h0, 1);
    n_vec++; if (bus.count !== 2'd0) begin n_miss++; $display("FAIL sclr_count: got %0d want 0", bus.count); end
    for (int c = 0; c < 4; c++) begin
      drive(0, 4'h0, 1);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL sclr_out c%0d: got %b want 0", c, bus.out_valid); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) != 0,
            ($urandom % 25) == 0, ($urandom % 25) == 0);
      n_vec++; if (bus.in_ready !== m_in_ready()) begin n_miss++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.in_ready, m_in_ready()); end
      n_vec++; if (bus.count !== 2'(q.size())) begin n_miss++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.count, q.size()); end
      n_vec++; if (bus.out_valid !== m_out_valid()) begin n_miss++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.out_valid, m_out_valid()); end
      if (m_out_valid()) begin
        n_vec++; if (bus.out_data !== m_out_data()) begin n_miss++; $display("FAIL rnd_data c%0d: got %h want %h", c, bus.out_data, m_out_data()); end
      end
`ifdef DFF_PIPE_PARITY_EN
      n_vec++; if (bus.par_err !== 1'b0) begin n_miss++; $display("FAIL rnd_par c%0d: got %b want 0", c, bus.par_err); end
`endif
      tick();
    end
    for (int c = 0; c < 4; c++) begin drive(0, 4'h0, 1); tick(); end
  endtask

`ifdef DFF_PIPE_PARITY_EN
  task automatic test_parity();
    drive(1, 4'h3, 0); tick();
    drive(0, 4'h0, 0); tick();
    drive(0, 4'h0, 0); tick();
    drive(0, 4'h0, 0);
    n_vec++; if (bus.par_err !== 1'b0) begin n_miss++; $display("FAIL par_clean: got %b want 0", bus.par_err); end
    force dut.g_stage[2].u_stage.r_d = 5'b1_0011;
    #1;
    n_vec++; if (bus.par_err !== 1'b1) begin n_miss++; $display("FAIL par_detect: got %b want 1", bus.par_err); end
    release dut.g_stage[2].u_stage.r_d;
    tick();
    drive(0, 4'h0, 0);
    n_vec++; if (bus.par_err !== 1'b1) begin n_miss++; $display("FAIL par_hold: got %b want 1", bus.par_err); end
    drive(0, 4'h0, 1); tick();
    drive(0, 4'h0, 0);
    n_vec++; if (bus.par_err !== 1'b0) begin n_miss++; $display("FAIL par_gone: got %b want 0", bus.par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_sset_sclr();
    test_random();
`ifdef DFF_PIPE_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
